// File: rtl/clk_tdc_multi_pkg.sv
// Shared types and helpers for the multi-channel clock TDC.
// Edge-mode codes, channel state encoding and a width helper.
package tdc_pkg;

  localparam logic [1:0] EDGE_RISE = 2'b00;
  localparam logic [1:0] EDGE_FALL = 2'b01;
  localparam logic [1:0] EDGE_BOTH = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } ch_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_tdc_multi_if.sv
// Result stream of the multi-channel TDC.
// Master drives the result, slave drives OUT_READY.
interface clk_tdc_multi_if #(
  parameter int CNT_W = 21,
  parameter int CH_W  = 2
);

  logic             OUT_VALID;
  logic             OUT_READY;
  logic [CNT_W-1:0] OUT_DATA;
  logic [CH_W-1:0]  OUT_CH;
  logic             OUT_SAT;
  logic             OUT_LOST;

  modport master (
    output OUT_VALID,
    output OUT_DATA,
    output OUT_CH,
    output OUT_SAT,
    output OUT_LOST,
    input  OUT_READY
  );

  modport slave (
    input  OUT_VALID,
    input  OUT_DATA,
    input  OUT_CH,
    input  OUT_SAT,
    input  OUT_LOST,
    output OUT_READY
  );

endinterface

// File: rtl/tdc_channel.sv
// One TDC channel: sync, optional filter, edge detect, counter, holding reg.
// Glitch filter built only when TDC_GLITCH_FILTER_EN is defined.
module tdc_channel
  import tdc_pkg::*;
#(
  parameter int CNT_W       = 21,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_i,
  input  logic [1:0]       edge_mode_i,
  input  logic             sig_i,
  input  logic             grant_i,
  output logic             pend_o,
  output logic [CNT_W-1:0] data_o,
  output logic             sat_o,
  output logic             lost_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   raw;
  logic                   lvl;
  logic                   prev_q;
  logic                   rise;
  logic                   fall;
  logic                   qual;

  ch_state_e        st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic             cap;

  logic             pend_q, pend_d;
  logic [CNT_W-1:0] hdata_q, hdata_d;
  logic             hsat_q, hsat_d;
  logic             lost_q, lost_d;

  // shift the async pin through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
  end

  assign raw = sync_q[SYNC_STAGES-1];

`ifdef TDC_GLITCH_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          filt_q, filt_d;

  // follow raw only after FILT_LEN cycles of a steady new level
  always_comb begin
    fcnt_d = '0;
    filt_d = filt_q;
    if (raw != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = raw;
      else                             fcnt_d = fcnt_q + 1'b1;
    end
  end

  // filter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt_q <= '0;
      filt_q <= 1'b0;
    end else begin
      fcnt_q <= fcnt_d;
      filt_q <= filt_d;
    end
  end

  assign lvl = filt_q;
`else
  logic unused_filt;
  assign unused_filt = ^FILT_LEN;
  assign lvl = raw;
`endif

  // one-cycle delay of the level for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= lvl;
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

  // qualify the edge; the reserved code behaves as rising
  always_comb begin
    qual = rise;
    unique case (1'b1)
      (edge_mode_i == EDGE_FALL): qual = fall;
      (edge_mode_i == EDGE_BOTH): qual = rise | fall;
      default:                    qual = rise;
    endcase
  end

  // channel FSM and saturating interval counter
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    cap   = 1'b0;
    if (!sw_i) begin
      st_d  = ST_IDLE;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (st_q == ST_IDLE) begin
      if (qual) begin
        st_d  = ST_MEAS;
        cnt_d = CNT_W'(1);
        sat_d = 1'b0;
      end
    end else if (qual) begin
      cap   = 1'b1;
      cnt_d = CNT_W'(1);
      sat_d = 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      sat_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // FSM and counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  // single-entry holding register; a grant frees it in the same cycle
  always_comb begin
    pend_d  = pend_q;
    hdata_d = hdata_q;
    hsat_d  = hsat_q;
    lost_d  = lost_q;
    if (grant_i) begin
      pend_d = 1'b0;
      lost_d = 1'b0;
    end
    if (cap) begin
      if (pend_q && !grant_i) begin
        lost_d = 1'b1;
      end else begin
        pend_d  = 1'b1;
        hdata_d = cnt_q;
        hsat_d  = sat_q;
      end
    end
  end

  // holding register state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= 1'b0;
      hdata_q <= '0;
      hsat_q  <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      pend_q  <= pend_d;
      hdata_q <= hdata_d;
      hsat_q  <= hsat_d;
      lost_q  <= lost_d;
    end
  end

  assign pend_o = pend_q;
  assign data_o = hdata_q;
  assign sat_o  = hsat_q;
  assign lost_o = lost_q;

endmodule

// File: rtl/clk_tdc_multi.sv
// Multi-channel clock TDC: channels, round-robin arbiter, output stage.
// Optional glitch filter per channel via TDC_GLITCH_FILTER_EN.
module clk_tdc_multi
  import tdc_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 21,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            SW,
  input  logic [1:0]      EDGE_MODE,
  input  logic [N_CH-1:0] SIG_IN,
  clk_tdc_multi_if.master res
);

  localparam int CH_W = clog2_min1(N_CH);

  logic [N_CH-1:0]  pend;
  logic [CNT_W-1:0] hdata [N_CH];
  logic [N_CH-1:0]  hsat;
  logic [N_CH-1:0]  hlost;
  logic [N_CH-1:0]  grant;

  logic [N_CH-1:0]  hi_m;
  logic [N_CH-1:0]  cand;
  logic [CH_W-1:0]  sel;
  logic             load;

  logic             vld_q, vld_d;
  logic [CNT_W-1:0] data_q, data_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             sat_q, sat_d;
  logic             lost_q, lost_d;
  logic [CH_W-1:0]  ptr_q, ptr_d;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    tdc_channel #(
      .CNT_W       (CNT_W),
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_LEN    (FILT_LEN)
    ) u_ch (
      .clk         (CLK),
      .rst_n       (RST),
      .sw_i        (SW),
      .edge_mode_i (EDGE_MODE),
      .sig_i       (SIG_IN[g]),
      .grant_i     (grant[g]),
      .pend_o      (pend[g]),
      .data_o      (hdata[g]),
      .sat_o       (hsat[g]),
      .lost_o      (hlost[g])
    );
  end

  // round-robin pick: lowest pending at or above ptr, else lowest overall
  always_comb begin
    hi_m = '0;
    sel  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (k >= int'(ptr_q)) hi_m = hi_m | (N_CH'(1) << k);
    end
    cand = (|(pend & hi_m)) ? (pend & hi_m) : pend;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (|(cand & (N_CH'(1) << k))) sel = CH_W'(k);
    end
  end

  assign load  = (|pend) && (!vld_q || res.OUT_READY);
  assign grant = load ? (N_CH'(1) << sel) : '0;

  // output stage: load a grant, or clear on handshake
  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    ch_d   = ch_q;
    sat_d  = sat_q;
    lost_d = lost_q;
    ptr_d  = ptr_q;
    if (load) begin
      vld_d  = 1'b1;
      data_d = hdata[sel];
      ch_d   = sel;
      sat_d  = hsat[sel];
      lost_d = hlost[sel];
      ptr_d  = (int'(sel) == N_CH - 1) ? '0 : sel + 1'b1;
    end else if (vld_q && res.OUT_READY) begin
      vld_d  = 1'b0;
      data_d = '0;
      ch_d   = '0;
      sat_d  = 1'b0;
      lost_d = 1'b0;
    end
  end

  // output registers and arbiter pointer
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      ch_q   <= '0;
      sat_q  <= 1'b0;
      lost_q <= 1'b0;
      ptr_q  <= '0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      ch_q   <= ch_d;
      sat_q  <= sat_d;
      lost_q <= lost_d;
      ptr_q  <= ptr_d;
    end
  end

  assign res.OUT_VALID = vld_q;
  assign res.OUT_DATA  = data_q;
  assign res.OUT_CH    = ch_q;
  assign res.OUT_SAT   = sat_q;
  assign res.OUT_LOST  = lost_q;

endmodule

// File: tb/tb_clk_tdc_multi.sv
// Scoreboard bench for clk_tdc_multi (N_CH=4, CNT_W=8).
// Expected results derive from SIG_IN edge times and the current EDGE_MODE.
module tb_clk_tdc_multi;

  localparam int NC    = 4;
  localparam int CW    = 8;
  localparam int MAXV  = (1 << CW) - 1;
`ifdef TDC_GLITCH_FILTER_EN
  localparam int LAT   = 2 + 2 + 3;
`else
  localparam int LAT   = 2 + 2;
`endif

  typedef struct {
    int data;
    bit sat;
    bit lost;
  } exp_t;

  logic          CLK;
  logic          RST;
  logic          SW;
  logic [1:0]    EDGE_MODE;
  logic [NC-1:0] SIG_IN;

  clk_tdc_multi_if #(.CNT_W(CW), .CH_W(2)) bus ();

  clk_tdc_multi #(
    .N_CH        (NC),
    .CNT_W       (CW),
    .SYNC_STAGES (2),
    .FILT_LEN    (3)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .SW        (SW),
    .EDGE_MODE (EDGE_MODE),
    .SIG_IN    (SIG_IN),
    .res       (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  exp_t expq [NC][$];
  int   exp_ord[$];
  int   ord_last = -1;
  bit   armed [NC];
  int   last_edge [NC];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic void chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic int qsize();
    int s = 0;
    for (int c = 0; c < NC; c++) s += expq[c].size();
    return s;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // drive one pin; a qualifying edge while armed yields the interval
  task automatic set_sig(input int ch, input bit v);
    bit   q;
    int   iv;
    exp_t e;
    if (SIG_IN[ch] != v) begin
      case (EDGE_MODE)
        2'b01:   q = !v;
        2'b10:   q = 1'b1;
        default: q = v;
      endcase
      SIG_IN[ch] = v;
      if (q && SW) begin
        if (armed[ch]) begin
          iv     = cyc - last_edge[ch];
          e.data = (iv > MAXV) ? MAXV : iv;
          e.sat  = (iv > MAXV);
          e.lost = 1'b0;
          expq[ch].push_back(e);
        end
        armed[ch]     = 1'b1;
        last_edge[ch] = cyc;
      end
    end
  endtask

  task automatic pulse_rise(input int ch, input int gap);
    set_sig(ch, 1'b1);
    tick(gap / 2);
    set_sig(ch, 1'b0);
    tick(gap - gap / 2);
  endtask

  task automatic set_sw(input bit v);
    SW = v;
    if (!v) for (int c = 0; c < NC; c++) armed[c] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    bus.OUT_READY = 1'b1;
    while (qsize() != 0 && t < 2000) begin
      tick(1);
      t++;
    end
    chk("drain_left", qsize(), 0);
    tick(10);
  endtask

  // monitor: pop and compare on every handshake, check stability on stalls
  bit   held = 1'b0;
  int   h_data, h_ch, h_sat, h_lost;
  int   mc;
  exp_t me;

  always @(negedge CLK) begin
    #1;
    if (!RST) begin
      held = 1'b0;
    end else if (bus.OUT_VALID) begin
      if (held) begin
        chk("hold_data", int'(bus.OUT_DATA), h_data);
        chk("hold_ch", int'(bus.OUT_CH), h_ch);
        chk("hold_sat", int'(bus.OUT_SAT), h_sat);
        chk("hold_lost", int'(bus.OUT_LOST), h_lost);
      end
      if (bus.OUT_READY) begin
        held = 1'b0;
        mc   = int'(bus.OUT_CH);
        if (expq[mc].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: ch=%0d data=%0d, none required (cycle %0d)",
                   mc, bus.OUT_DATA, cyc);
        end else begin
          me = expq[mc].pop_front();
          chk("data", int'(bus.OUT_DATA), me.data);
          chk("sat", int'(bus.OUT_SAT), int'(me.sat));
          chk("lost", int'(bus.OUT_LOST), int'(me.lost));
        end
        if (exp_ord.size() > 0) begin
          chk("order_ch", mc, exp_ord.pop_front());
          if (ord_last >= 0) chk("order_gap", cyc - ord_last, 1);
          ord_last = cyc;
        end
      end else begin
        held   = 1'b1;
        h_data = int'(bus.OUT_DATA);
        h_ch   = int'(bus.OUT_CH);
        h_sat  = int'(bus.OUT_SAT);
        h_lost = int'(bus.OUT_LOST);
      end
    end else if (held) begin
      chk("hold_valid", 0, 1);
      held = 1'b0;
    end
  end

  int   lat;
  int   cd [NC];
  int   stall;
  exp_t eb;

  initial begin
    RST           = 1'b0;
    SW            = 1'b0;
    EDGE_MODE     = 2'b00;
    SIG_IN        = '0;
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < NC; c++) begin
      armed[c]     = 1'b0;
      last_edge[c] = 0;
    end
    tick(3);
    chk("rst_valid", int'(bus.OUT_VALID), 0);
    chk("rst_data", int'(bus.OUT_DATA), 0);
    chk("rst_ch", int'(bus.OUT_CH), 0);
    chk("rst_sat", int'(bus.OUT_SAT), 0);
    chk("rst_lost", int'(bus.OUT_LOST), 0);
    RST = 1'b1;
    tick(2);
    set_sw(1'b1);
    tick(2);

    // ch0 rising every 20 cycles, latency on the second edge
    lat = -1;
    for (int p = 0; p < 6; p++) begin
      set_sig(0, 1'b1);
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (p == 1 && lat < 0 && bus.OUT_VALID) lat = i + 1;
      end
      set_sig(0, 1'b0);
      tick(10);
    end
    chk("latency", lat, LAT);
    drain();

    // both edges, 11/11 square wave on ch2
    EDGE_MODE = 2'b10;
    tick(2);
    for (int p = 0; p < 8; p++) begin
      set_sig(2, !SIG_IN[2]);
      tick(11);
    end
    drain();
    EDGE_MODE = 2'b00;
    tick(5);

    // saturation boundaries on ch1
    pulse_rise(1, 300);
    pulse_rise(1, 40);
    pulse_rise(1, 255);
    pulse_rise(1, 256);
    set_sig(1, 1'b1);
    tick(3);
    set_sig(1, 1'b0);
    drain();

    // backpressure: the third interval is dropped on ch3
    bus.OUT_READY = 1'b0;
    pulse_rise(3, 10);
    pulse_rise(3, 10);
    pulse_rise(3, 10);
    set_sig(3, 1'b1);
    tick(10);
    chk("bp_valid", int'(bus.OUT_VALID), 1);
    chk("bp_data", int'(bus.OUT_DATA), 10);
    chk("bp_ch", int'(bus.OUT_CH), 3);
    chk("bp_lost", int'(bus.OUT_LOST), 0);
    void'(expq[3].pop_back());
    eb = expq[3].pop_back();
    eb.lost = 1'b1;
    expq[3].push_back(eb);
    set_sig(3, 1'b0);
    tick(5);
    drain();

    // async reset with results pending
    bus.OUT_READY = 1'b0;
    pulse_rise(0, 20);
    pulse_rise(0, 20);
    set_sig(0, 1'b1);
    tick(6);
    chk("pre_rst_valid", int'(bus.OUT_VALID), 1);
    #3;
    RST = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.OUT_VALID), 0);
    for (int c = 0; c < NC; c++) begin
      expq[c].delete();
      armed[c] = 1'b0;
    end
    SIG_IN = '0;
    tick(3);
    RST = 1'b1;
    bus.OUT_READY = 1'b1;
    tick(3);

    // shared edges on all channels: round-robin from channel 0
    for (int c = 0; c < NC; c++) set_sig(c, 1'b1);
    tick(7);
    for (int c = 0; c < NC; c++) set_sig(c, 1'b0);
    tick(8);
    ord_last = -1;
    for (int c = 0; c < NC; c++) set_sig(c, 1'b1);
    for (int c = 0; c < NC; c++) exp_ord.push_back(c);
    drain();
    chk("order_left", exp_ord.size(), 0);
    for (int c = 0; c < NC; c++) set_sig(c, 1'b0);
    tick(10);

    // disarm returns channels to idle
    set_sw(1'b0);
    tick(5);
    set_sw(1'b1);
    tick(3);
    pulse_rise(0, 25);
    pulse_rise(0, 25);
    set_sig(0, 1'b1);
    tick(3);
    set_sig(0, 1'b0);
    drain();

    // random toggling in every edge mode with random backpressure
    for (int m = 0; m < 4; m++) begin
      tick(30);
      EDGE_MODE = 2'(m);
      tick(2);
      stall = 0;
      for (int c = 0; c < NC; c++) cd[c] = $urandom_range(70, 20);
      repeat (1500) begin
        for (int c = 0; c < NC; c++) begin
          cd[c]--;
          if (cd[c] == 0) begin
            set_sig(c, !SIG_IN[c]);
            cd[c] = $urandom_range(70, 20);
          end
        end
        if (stall >= 2) bus.OUT_READY = 1'b1;
        else            bus.OUT_READY = 1'($urandom_range(1, 0));
        stall = bus.OUT_READY ? 0 : stall + 1;
        tick(1);
      end
      drain();
    end

    tick(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
